// File: rtl/sdrc_wb_arb_pkg.sv
// sdrc_wb_arb_pkg: shared definitions for the multi-port Wishbone front end.
// Holds the Wishbone cycle-type codes, the arbiter FSM state encoding and a
// small helper that turns a one-hot grant into a port index.
package sdrc_wb_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WR,
        ST_RD
    } state_t;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = idx | 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/sdrc_wb_arb_rr.sv
// sdrc_rr_arb: combinational round-robin picker.
// Ports:
//   req  - per-port request vector
//   last - index of the most recently served port
//   en   - when low no grant is produced
//   gnt  - one-hot grant to the first requester after last, in circular order
module sdrc_rr_arb #(
    parameter int NP = 2,
    localparam int LW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic [NP-1:0] req,
    input  logic [LW-1:0] last,
    input  logic          en,
    output logic [NP-1:0] gnt
);

    logic          found;
    logic [LW-1:0] idx;

    // Scan last+1, last+2, ... wrapping round; the first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NP; i++) begin
            idx = LW'((int'(last) + i) % NP);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdrc_wb_arb.sv
// sdrc_wb_arb: round-robin arbiter of NP Wishbone slave ports onto the single
// sdrc_core application request interface, all in the SDRAM clock domain.
// Ports:
//   wb_clk_i, wb_rst_i          - clock, asynchronous active-high reset
//   wb_cyc/stb/we/addr/dat/sel/cti_i - per-port Wishbone inputs, port p in slice p
//   wb_ack_o, wb_dat_o          - per-port ack, shared read data
//   grant_o                     - one-hot current owner, zero when idle
//   burst_err_o                 - sticky: write beat consumed with owner stb low
//   sdr_init_done               - gates new grants
//   app_req*, app_wr_*, app_rd_*, app_last_rd - sdrc_core application side
module sdrc_wb_arb
    import sdrc_wb_arb_pkg::*;
#(
    parameter int NP        = 2,
    parameter int AW        = 25,
    parameter int DW        = 32,
    parameter int BL        = 9,
    parameter int BURST_LEN = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NP-1:0]    wb_cyc_i,
    input  logic [NP-1:0]    wb_stb_i,
    input  logic [NP-1:0]    wb_we_i,
    input  logic [NP*AW-1:0] wb_addr_i,
    input  logic [NP*DW-1:0] wb_dat_i,
    input  logic [NP*DW/8-1:0] wb_sel_i,
    input  logic [NP*3-1:0]  wb_cti_i,
    output logic [NP-1:0]    wb_ack_o,
    output logic [DW-1:0]    wb_dat_o,
    output logic [NP-1:0]    grant_o,
    output logic             burst_err_o,
    input  logic             sdr_init_done,
    output logic             app_req,
    output logic [AW-1:0]    app_req_addr,
    output logic [BL-1:0]    app_req_len,
    output logic             app_req_wr_n,
    input  logic             app_req_ack,
    input  logic             app_wr_next_req,
    output logic [DW-1:0]    app_wr_data,
    output logic [DW/8-1:0]  app_wr_en_n,
    input  logic             app_rd_valid,
    input  logic [DW-1:0]    app_rd_data,
    input  logic             app_last_rd
);

    localparam int LW = (NP > 1) ? $clog2(NP) : 1;
    localparam int SW = DW / 8;

    state_t        state, state_nxt;
    logic [LW-1:0] owner, rr_last, win_idx;
    logic [AW-1:0] lat_addr;
    logic          lat_we;
    logic [BL-1:0] lat_len, beat_cnt, beat_nxt;
    logic          burst_err;
    logic [NP-1:0] req, gnt;
    logic          go, wr_beat, rd_beat, done;
    logic          own_cyc, own_stb;
    logic [DW-1:0] own_dat;
    logic [SW-1:0] own_sel;
    logic [AW-1:0] win_addr;
    logic          win_we;
    logic [2:0]    win_cti;

    assign req = wb_cyc_i & wb_stb_i;

    sdrc_rr_arb #(.NP(NP)) u_arb (
        .req  (req),
        .last (rr_last),
        .en   (sdr_init_done && state == ST_IDLE),
        .gnt  (gnt)
    );

    assign go      = |gnt;
    assign win_idx = LW'(oh2idx(8'(gnt)));

    // Candidate port fields, sampled only on the grant cycle.
    assign win_addr = wb_addr_i[win_idx*AW +: AW];
    assign win_we   = wb_we_i[win_idx];
    assign win_cti  = wb_cti_i[win_idx*3 +: 3];

    // Owner port fields, used while a transfer is in progress.
    assign own_cyc = wb_cyc_i[owner];
    assign own_stb = wb_stb_i[owner];
    assign own_dat = wb_dat_i[owner*DW +: DW];
    assign own_sel = wb_sel_i[owner*SW +: SW];

    assign beat_nxt = beat_cnt + 1'b1;
    assign wr_beat  = state == ST_WR && app_wr_next_req;
    assign rd_beat  = state == ST_RD && app_rd_valid;
    // A read may end early on app_last_rd; a write always runs to the latched length.
    assign done     = (wr_beat && beat_nxt == lat_len) ||
                      (rd_beat && (app_last_rd || beat_nxt == lat_len));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = go ? ST_REQ : ST_IDLE;
            ST_REQ:  state_nxt = app_req_ack ? (lat_we ? ST_WR : ST_RD) : ST_REQ;
            ST_WR,
            ST_RD:   state_nxt = done ? ST_IDLE : state;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        app_req      = state == ST_REQ;
        app_req_wr_n = !(state == ST_REQ && lat_we);
        app_req_addr = lat_addr;
        app_req_len  = lat_len;
        grant_o      = (state == ST_IDLE) ? '0 : NP'(1) << owner;
        app_wr_data  = (state == ST_WR) ? own_dat : '0;
        // A beat pulled while the owner has stb low is written fully masked.
        app_wr_en_n  = (state == ST_WR && own_stb) ? ~own_sel : '1;
        wb_dat_o     = (state == ST_RD) ? app_rd_data : '0;
        wb_ack_o     = ((wr_beat && own_stb) || (rd_beat && own_cyc)) ? grant_o : '0;
        burst_err_o  = burst_err;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            owner     <= '0;
            rr_last   <= LW'(NP - 1);
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_len   <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            if (go) begin
                owner    <= win_idx;
                lat_addr <= win_addr;
                lat_we   <= win_we;
                lat_len  <= (win_cti == CTI_INCR) ? BL'(BURST_LEN) : BL'(1);
                beat_cnt <= '0;
            end
            if (wr_beat || rd_beat)
                beat_cnt <= beat_nxt;
            if (wr_beat && !own_stb)
                burst_err <= 1'b1;
            if (done)
                rr_last <= owner;
        end
    end

endmodule

// File: tb/tb_sdrc_wb_arb.sv
// tb_sdrc_wb_arb: self-checking bench for sdrc_wb_arb (NP=2) acting as both
// Wishbone masters and the SDRAM controller, with a word memory behind it.
module tb_sdrc_wb_arb;

    localparam int NP = 2;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int BL = 9;
    localparam int SW = DW / 8;

    logic             clk, rst;
    logic [NP-1:0]    wb_cyc_i, wb_stb_i, wb_we_i;
    logic [NP*AW-1:0] wb_addr_i;
    logic [NP*DW-1:0] wb_dat_i;
    logic [NP*SW-1:0] wb_sel_i;
    logic [NP*3-1:0]  wb_cti_i;
    logic [NP-1:0]    wb_ack_o, grant_o;
    logic [DW-1:0]    wb_dat_o;
    logic             burst_err_o, sdr_init_done;
    logic             app_req, app_req_wr_n, app_req_ack, app_wr_next_req;
    logic [AW-1:0]    app_req_addr;
    logic [BL-1:0]    app_req_len;
    logic [DW-1:0]    app_wr_data, app_rd_data;
    logic [SW-1:0]    app_wr_en_n;
    logic             app_rd_valid, app_last_rd;

    logic [AW-1:0] m_addr [NP];
    logic [DW-1:0] m_dat  [NP];
    logic [SW-1:0] m_sel  [NP];
    logic [2:0]    m_cti  [NP];
    int            m_beat [NP];

    logic [DW-1:0] mem [logic [AW-1:0]];

    int checks = 0;
    int errors = 0;
    int mdl_last = NP - 1;

    typedef struct {
        int            port;
        logic          we;
        logic [2:0]    cti;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            exp_len;
        logic          exp_wr_n;
        logic [SW-1:0] exp_en_n;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tv [6];
    logic [2:0] ctis [3];
    logic [NP-1:0] pending;
    int n, w;
    int exp_order [6];

    sdrc_wb_arb #(.NP(NP), .AW(AW), .DW(DW), .BL(BL), .BURST_LEN(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cti_i(wb_cti_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .grant_o(grant_o), .burst_err_o(burst_err_o), .sdr_init_done(sdr_init_done),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
        .app_wr_next_req(app_wr_next_req), .app_wr_data(app_wr_data),
        .app_wr_en_n(app_wr_en_n), .app_rd_valid(app_rd_valid),
        .app_rd_data(app_rd_data), .app_last_rd(app_last_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The master advances its data on every acked beat.
    always_comb begin
        wb_addr_i = '0;
        wb_dat_i  = '0;
        wb_sel_i  = '0;
        wb_cti_i  = '0;
        for (int p = 0; p < NP; p++) begin
            wb_addr_i[p*AW +: AW] = m_addr[p];
            wb_dat_i[p*DW +: DW]  = m_dat[p] + DW'(m_beat[p]);
            wb_sel_i[p*SW +: SW]  = m_sel[p];
            wb_cti_i[p*3 +: 3]    = m_cti[p];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : (32'(a) ^ 32'h5A5A0000);
    endfunction

    function automatic int mdl_len(input logic [2:0] cti);
        return (cti == 3'b010) ? 4 : 1;
    endfunction

    function automatic int mdl_pick(input logic [NP-1:0] pend, input int last);
        for (int k = 1; k <= NP; k++)
            if (pend[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    task automatic setm(input int p, input logic we, input logic [2:0] cti,
                        input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel);
        wb_cyc_i[p] = 1'b1;
        wb_stb_i[p] = 1'b1;
        wb_we_i[p]  = we;
        m_cti[p]    = cti;
        m_addr[p]   = addr;
        m_dat[p]    = dat;
        m_sel[p]    = sel;
        m_beat[p]   = 0;
    endtask

    task automatic clrm(input int p);
        wb_cyc_i[p] = 1'b0;
        wb_stb_i[p] = 1'b0;
        m_beat[p]   = 0;
    endtask

    // Plays the controller for one whole transaction expected on port p.
    task automatic serve(input int p, input int exp_len, input logic exp_wr_n,
                         input logic [SW-1:0] exp_en_n, input int drop_beat,
                         input bit chk_rd0, input logic [DW-1:0] exp_rd0);
        int cnt;
        logic [AW-1:0] base;
        logic [DW-1:0] d;
        cnt = 0;
        while (!app_req && cnt < 20) begin
            step();
            cnt++;
        end
        chk("req_seen", app_req, 1);
        if (!app_req) begin
            clrm(p);
            return;
        end
        chk("grant", grant_o, 1 << p);
        chk("req_len", app_req_len, exp_len);
        chk("req_wr_n", app_req_wr_n, exp_wr_n);
        chk("req_addr", app_req_addr, m_addr[p]);
        base = app_req_addr;
        repeat ($urandom_range(0, 2)) step();
        chk("req_hold", app_req, 1);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        chk("req_drop", app_req, 0);
        for (int b = 0; b < exp_len; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                #1;
                chk("gap_ack", wb_ack_o, 0);
                step();
            end
            if (wb_we_i[p]) begin
                if (b == drop_beat) wb_stb_i[p] = 1'b0;
                app_wr_next_req = 1'b1;
                #1;
                chk("wr_data", app_wr_data, m_dat[p] + DW'(m_beat[p]));
                chk("wr_en_n", app_wr_en_n, (b == drop_beat) ? {SW{1'b1}} : exp_en_n);
                chk("wr_ack", wb_ack_o, (b == drop_beat) ? 0 : (1 << p));
                d = mem_rd(base + AW'(b));
                for (int k = 0; k < SW; k++)
                    if (!app_wr_en_n[k]) d[8*k +: 8] = app_wr_data[8*k +: 8];
                mem[base + AW'(b)] = d;
                step();
                app_wr_next_req = 1'b0;
                if (b == drop_beat) wb_stb_i[p] = 1'b1;
                else m_beat[p]++;
            end else begin
                d = mem_rd(base + AW'(b));
                app_rd_valid = 1'b1;
                app_rd_data  = d;
                app_last_rd  = (b == exp_len - 1);
                #1;
                chk("rd_data", wb_dat_o, d);
                chk("rd_ack", wb_ack_o, 1 << p);
                if (b == 0 && chk_rd0) chk("rd_value", wb_dat_o, exp_rd0);
                step();
                app_rd_valid = 1'b0;
                app_last_rd  = 1'b0;
                m_beat[p]++;
            end
        end
        clrm(p);
        #1;
        chk("end_idle", grant_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc_i = '0;
        wb_stb_i = '0;
        wb_we_i = '0;
        sdr_init_done = 1'b1;
        app_req_ack = 1'b0;
        app_wr_next_req = 1'b0;
        app_rd_valid = 1'b0;
        app_rd_data = '0;
        app_last_rd = 1'b0;
        for (int p = 0; p < NP; p++) setm(p, 1'b0, 3'b000, '0, '0, '0);
        for (int p = 0; p < NP; p++) clrm(p);
        ctis = '{3'b000, 3'b010, 3'b111};
        exp_order = '{0, 1, 0, 1, 0, 1};
        tv[0] = '{0, 1'b1, 3'b000, 25'h100, 32'hDEADBEEF, 4'hF, 1, 1'b0, 4'h0, 32'h0};
        tv[1] = '{0, 1'b0, 3'b000, 25'h100, 32'h0,        4'hF, 1, 1'b1, 4'h0, 32'hDEADBEEF};
        tv[2] = '{1, 1'b1, 3'b010, 25'h300, 32'hA0000000, 4'hF, 4, 1'b0, 4'h0, 32'h0};
        tv[3] = '{1, 1'b0, 3'b010, 25'h300, 32'h0,        4'hF, 4, 1'b1, 4'h0, 32'hA0000000};
        tv[4] = '{0, 1'b1, 3'b111, 25'h200, 32'h11223344, 4'h5, 1, 1'b0, 4'hA, 32'h0};
        tv[5] = '{1, 1'b0, 3'b000, 25'h200, 32'h0,        4'hF, 1, 1'b1, 4'h0, 32'h5A220244};
        step();
        step();
        chk("rst_app_req", app_req, 0);
        chk("rst_wr_n", app_req_wr_n, 1);
        chk("rst_en_n", app_wr_en_n, 4'hF);
        chk("rst_grant", grant_o, 0);
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_err", burst_err_o, 0);
        rst = 1'b0;
        step();

        // Both ports requesting every round: service must alternate from port 0.
        for (int r = 0; r < 6; r += 2) begin
            setm(0, 1'b1, 3'b000, 25'h10 + AW'(r), 32'h1000 + DW'(r), 4'hF);
            setm(1, 1'b1, 3'b000, 25'h20 + AW'(r), 32'h2000 + DW'(r), 4'hF);
            serve(exp_order[r], 1, 1'b0, 4'h0, -1, 0, 0);
            serve(exp_order[r + 1], 1, 1'b0, 4'h0, -1, 0, 0);
        end
        mdl_last = 1;

        for (int i = 0; i < 6; i++) begin
            setm(tv[i].port, tv[i].we, tv[i].cti, tv[i].addr, tv[i].dat, tv[i].sel);
            serve(tv[i].port, tv[i].exp_len, tv[i].exp_wr_n, tv[i].exp_en_n, -1,
                  !tv[i].we, tv[i].exp_rd);
            mdl_last = tv[i].port;
        end

        // Owner drops stb on the second beat of a write burst.
        chk("err_before", burst_err_o, 0);
        setm(0, 1'b1, 3'b010, 25'h500, 32'h77000000, 4'hF);
        serve(0, 4, 1'b0, 4'h0, 1, 0, 0);
        chk("err_after", burst_err_o, 1);
        mdl_last = 0;

        // No grant while the controller is still initialising.
        sdr_init_done = 1'b0;
        setm(1, 1'b0, 3'b000, 25'h100, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("init_block", app_req, 0);
        end
        sdr_init_done = 1'b1;
        #1;
        chk("init_edge", app_req, 0);
        step();
        chk("init_req", app_req, 1);
        serve(1, 1, 1'b1, 4'h0, -1, 1, 32'hDEADBEEF);
        mdl_last = 1;
        chk("err_sticky", burst_err_o, 1);

        for (int r = 0; r < 40; r++) begin
            pending = NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++)
                if (pending[p])
                    setm(p, 1'($urandom_range(0, 1)), ctis[$urandom_range(0, 2)],
                         25'h1000 + AW'($urandom_range(0, 63)), $urandom, SW'($urandom));
            while (pending != 0) begin
                w = mdl_pick(pending, mdl_last);
                serve(w, mdl_len(m_cti[w]), !wb_we_i[w], ~m_sel[w], -1, 0, 0);
                pending[w] = 1'b0;
                mdl_last = w;
            end
        end

        // Asynchronous reset in the middle of a read burst.
        setm(1, 1'b0, 3'b010, 25'h300, 32'h0, 4'hF);
        n = 0;
        while (!app_req && n < 20) begin
            step();
            n++;
        end
        chk("rrd_req", app_req, 1);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        app_rd_valid = 1'b1;
        app_rd_data = 32'h55;
        step();
        #1;
        chk("rrd_data", wb_dat_o, 32'h55);
        rst = 1'b1;
        #1;
        chk("rrd_dat0", wb_dat_o, 0);
        chk("rrd_ack", wb_ack_o, 0);
        chk("rrd_grant", grant_o, 0);
        chk("rrd_app_req", app_req, 0);
        chk("rrd_wr_n", app_req_wr_n, 1);
        chk("rrd_en_n", app_wr_en_n, 4'hF);
        chk("rrd_wdata", app_wr_data, 0);
        chk("rrd_err", burst_err_o, 0);
        app_rd_valid = 1'b0;
        app_rd_data = '0;
        clrm(1);
        step();
        rst = 1'b0;
        mdl_last = NP - 1;
        setm(0, 1'b0, 3'b000, 25'h100, 32'h0, 4'hF);
        setm(1, 1'b1, 3'b000, 25'h600, 32'hCAFE0000, 4'h3);
        pending = '1;
        while (pending != 0) begin
            w = mdl_pick(pending, mdl_last);
            serve(w, 1, !wb_we_i[w], ~m_sel[w], -1, w == 0, 32'hDEADBEEF);
            pending[w] = 1'b0;
            mdl_last = w;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
